// File: rtl/hazard_pipe_tracker_if.sv
// EX/MEM/WB destination-register tracking interface between the ID stage
// and the forwarding/bubble unit.
interface hazard_pipe_tracker_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rw;
    logic             id_we;
    logic             id_is_load;
    logic             bubble_in;
    logic             flush;
    logic [REG_W-1:0] rw_exe;
    logic             WE_exe_alu;
    logic             WE_exe_mem;
    logic [REG_W-1:0] rw_mem;
    logic             WE_mem;
    logic [REG_W-1:0] rw_wb;
    logic             WE_wb;
    logic             stall_if_id;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rw, id_we, id_is_load, bubble_in, flush,
        input  rw_exe, WE_exe_alu, WE_exe_mem, rw_mem, WE_mem, rw_wb, WE_wb,
               stall_if_id, bubble_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rw, id_we, id_is_load, bubble_in, flush,
        output rw_exe, WE_exe_alu, WE_exe_mem, rw_mem, WE_mem, rw_wb, WE_wb,
               stall_if_id, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// Tracks destination register / write-enable / load flag of in-flight
// instructions through EX, MEM, WB; inserts NOPs on bubbles and flushes.
module hazard_pipe_tracker #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_pipe_tracker_if.slave bus
);
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rw;
        logic             we;
        logic             ld;
    } entry_t;

    entry_t           ex_q, mem_q, wb_q, id_entry;
    logic             accept, rw_nz, bubble_ev, flush_ev;
    logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q;

    always_comb begin
        accept    = bus.id_valid & ~bus.bubble_in & ~bus.flush;
        rw_nz     = |bus.id_rw;
        bubble_ev = bus.bubble_in & ~bus.flush & bus.id_valid;
        flush_ev  = bus.flush & bus.id_valid;
        id_entry  = '0;
        if (accept) begin
            // r0 writes are never tracked as writers
            id_entry.v  = 1'b1;
            id_entry.rw = bus.id_rw;
            id_entry.we = bus.id_we & rw_nz;
            id_entry.ld = bus.id_is_load & bus.id_we & rw_nz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q  <= id_entry;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (bubble_ev && !(&bubble_cnt_q))
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            if (flush_ev && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.rw_exe      = ex_q.v  ? ex_q.rw  : '0;
    assign bus.rw_mem      = mem_q.v ? mem_q.rw : '0;
    assign bus.rw_wb       = wb_q.v  ? wb_q.rw  : '0;
    assign bus.WE_exe_alu  = ex_q.v & ex_q.we & ~ex_q.ld;
    assign bus.WE_exe_mem  = ex_q.v & ex_q.we & ex_q.ld;
    assign bus.WE_mem      = mem_q.v & mem_q.we;
    assign bus.WE_wb       = wb_q.v & wb_q.we;
    assign bus.stall_if_id = bus.bubble_in & ~bus.flush;
    assign bus.bubble_cnt  = bubble_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Self-checking bench for hazard_pipe_tracker: directed scenarios plus random
// traffic against a history-queue reference model.
module tb_hazard_pipe_tracker;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;
    localparam int MAXC = (1 << CNT_W) - 1;

    typedef struct {
        bit v;
        int rw;
        bit we;
        bit ld;
    } ment_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    ment_t hist[$];
    int    exp_bcnt, exp_fcnt;

    hazard_pipe_tracker_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
    hazard_pipe_tracker #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input bit v, input int rw, input bit we, input bit ld,
                          input bit bub, input bit fl, input bit r);
        bus.id_valid   = v;
        bus.id_rw      = rw[REG_W-1:0];
        bus.id_we      = we;
        bus.id_is_load = ld;
        bus.bubble_in  = bub;
        bus.flush      = fl;
        rst            = r;
    endtask

    // Model: the instruction that entered EX at each edge, oldest first
    task automatic model_edge();
        ment_t e;
        e = '{v: 0, rw: 0, we: 0, ld: 0};
        if (rst) begin
            hist = {e, e, e};
            exp_bcnt = 0;
            exp_fcnt = 0;
        end else begin
            if (bus.id_valid && !bus.bubble_in && !bus.flush) begin
                e.v  = 1;
                e.rw = int'(bus.id_rw);
                e.we = bus.id_we && (bus.id_rw != 0);
                e.ld = bus.id_we && bus.id_is_load && (bus.id_rw != 0);
            end
            hist.push_back(e);
            void'(hist.pop_front());
            if (bus.id_valid && bus.bubble_in && !bus.flush && exp_bcnt < MAXC) exp_bcnt++;
            if (bus.id_valid && bus.flush && exp_fcnt < MAXC) exp_fcnt++;
        end
    endtask

    task automatic check_all();
        ment_t ex, mem, wb;
        ex = hist[2]; mem = hist[1]; wb = hist[0];
        chk("rw_exe",     bus.rw_exe,     ex.v ? ex.rw : 0);
        chk("WE_exe_alu", bus.WE_exe_alu, ex.v && ex.we && !ex.ld);
        chk("WE_exe_mem", bus.WE_exe_mem, ex.v && ex.we && ex.ld);
        chk("rw_mem",     bus.rw_mem,     mem.v ? mem.rw : 0);
        chk("WE_mem",     bus.WE_mem,     mem.v && mem.we);
        chk("rw_wb",      bus.rw_wb,      wb.v ? wb.rw : 0);
        chk("WE_wb",      bus.WE_wb,      wb.v && wb.we);
        chk("bubble_cnt", bus.bubble_cnt, exp_bcnt);
        chk("flush_cnt",  bus.flush_cnt,  exp_fcnt);
    endtask

    // Check stall before the edge, clock, then check registered state
    task automatic step(input bit full = 1);
        #1;
        chk("stall_if_id", bus.stall_if_id, bus.bubble_in && !bus.flush);
        @(posedge clk);
        model_edge();
        #1;
        if (full) check_all();
        else chk("bubble_cnt", bus.bubble_cnt, exp_bcnt);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        step();
        chk("reset_rw_exe", bus.rw_exe, 0);
        chk("reset_bcnt", bus.bubble_cnt, 0);

        // ALU write to r5 propagates EX -> MEM -> WB
        set_in(1, 5, 1, 0, 0, 0, 0); step();
        chk("r5_exe", bus.rw_exe, 5);
        chk("r5_we_alu", bus.WE_exe_alu, 1);
        set_in(0, 0, 0, 0, 0, 0, 0); step();
        chk("r5_mem", bus.rw_mem, 5);
        step();
        chk("r5_wb", bus.rw_wb, 5);
        chk("r5_we_wb", bus.WE_wb, 1);

        // Load to r8 followed by a one-cycle load-use bubble
        set_in(1, 8, 1, 1, 0, 0, 0); step();
        chk("ld_we_mem", bus.WE_exe_mem, 1);
        set_in(1, 9, 1, 0, 1, 0, 0);
        #1 chk("bub_stall", bus.stall_if_id, 1);
        step();
        chk("bub_ex_nop", bus.WE_exe_alu | bus.WE_exe_mem, 0);
        chk("bub_rw_mem", bus.rw_mem, 8);
        chk("bub_cnt1", bus.bubble_cnt, 1);
        set_in(1, 9, 1, 0, 0, 0, 0); step();
        chk("reissue_exe", bus.rw_exe, 9);

        // Flush beats bubble
        set_in(1, 4, 1, 0, 1, 1, 0);
        #1 chk("fl_stall", bus.stall_if_id, 0);
        step();
        chk("fl_ex_nop", bus.rw_exe, 0);
        chk("fl_cnt", bus.flush_cnt, 1);
        chk("fl_bcnt", bus.bubble_cnt, 1);

        // r0 write never tracked
        set_in(1, 0, 1, 1, 0, 0, 0); step();
        chk("r0_we", bus.WE_exe_alu | bus.WE_exe_mem, 0);

        // Store tracked as non-writer
        set_in(1, 7, 0, 1, 0, 0, 0); step();
        chk("st_rw", bus.rw_exe, 7);
        chk("st_we", bus.WE_exe_mem, 0);

        // Reset mid-operation
        set_in(1, 1, 1, 0, 0, 0, 0); step();
        set_in(1, 2, 1, 0, 0, 0, 0); step();
        set_in(1, 3, 1, 0, 0, 0, 0); step();
        set_in(1, 6, 1, 0, 1, 0, 1); step();
        chk("rst_rw_wb", bus.rw_wb, 0);
        chk("rst_fcnt", bus.flush_cnt, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom % 4) != 0, ($urandom % 3 == 0) ? 0 : $urandom % 32,
                   $urandom % 2, $urandom % 2, ($urandom % 4) == 0,
                   ($urandom % 8) == 0, ($urandom % 60) == 0);
            step();
        end

        // Bubble counter saturation
        set_in(0, 0, 0, 0, 0, 0, 1); step();
        set_in(1, 3, 1, 0, 1, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step(0);
        check_all();
        chk("bcnt_sat", bus.bubble_cnt, MAXC);
        step();
        chk("bcnt_nowrap", bus.bubble_cnt, MAXC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
